// File: rtl/serial_rx.sv
// serial_rx: two independent MSB-first serial lanes, each aligned on the COM symbol.
// A lane goes active after COM_COUNT consecutive aligned COMs and then emits data bytes.
module serial_rx #(
    parameter int unsigned          MAIN_SIZE = 8,
    parameter logic [MAIN_SIZE-1:0] COM       = MAIN_SIZE'(8'hBC),
    parameter int unsigned          COM_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in0,
    input  logic                 in1,
    output logic [MAIN_SIZE-1:0] out0,
    output logic                 valid0,
    output logic                 active0,
    output logic [MAIN_SIZE-1:0] out1,
    output logic                 valid1,
    output logic                 active1,
    output logic                 Error
);

    localparam int unsigned BC_W = $clog2(MAIN_SIZE);

    typedef enum logic [1:0] {
        StSearch,
        StLock,
        StActive
    } state_e;

    logic [1:0] w_in;
    logic [1:0] w_err;
    logic       r_error;

    assign w_in = {in1, in0};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        state_e                r_state;
        logic [MAIN_SIZE-1:0]  r_sr;
        logic [MAIN_SIZE-1:0]  r_out;
        logic [BC_W-1:0]       r_bc;
        logic [2:0]            r_cc;
        logic                  r_valid;
        logic                  r_active;
        logic [MAIN_SIZE-1:0]  w_nxt;
        logic [2:0]            w_cc_inc;
        logic                  w_com;
        logic                  w_bnd;

        assign w_nxt    = {r_sr[MAIN_SIZE-2:0], w_in[g]};
        assign w_com    = (w_nxt == COM);
        // Boundary: the cycle in which the last bit of an aligned symbol arrives.
        assign w_bnd    = (r_bc == BC_W'(MAIN_SIZE - 1));
        assign w_cc_inc = r_cc + 3'd1;
        assign w_err[g] = (r_state == StLock) && w_bnd && !w_com;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state  <= StSearch;
                r_sr     <= '0;
                r_bc     <= '0;
                r_cc     <= '0;
                r_out    <= '0;
                r_valid  <= 1'b0;
                r_active <= 1'b0;
            end else begin
                r_sr    <= w_nxt;
                r_valid <= 1'b0;
                r_bc    <= r_bc + BC_W'(1);
                case (r_state)
                    StSearch: begin
                        if (w_com) begin
                            r_state <= StLock;
                            r_bc    <= '0;
                            r_cc    <= 3'd1;
                        end
                    end
                    StLock: begin
                        if (w_bnd) begin
                            if (w_com) begin
                                r_cc <= w_cc_inc;
                                if (w_cc_inc == 3'(COM_COUNT)) begin
                                    r_state  <= StActive;
                                    r_active <= 1'b1;
                                end
                            end else begin
                                r_state <= StSearch;
                                r_cc    <= '0;
                            end
                        end
                    end
                    StActive: begin
                        // COMs in ACTIVE are idle fill and never reach the output.
                        if (w_bnd && !w_com) begin
                            r_out   <= w_nxt;
                            r_valid <= 1'b1;
                        end
                    end
                    default: r_state <= StSearch;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= |w_err;
        end
    end

    assign out0    = g_lane[0].r_out;
    assign valid0  = g_lane[0].r_valid;
    assign active0 = g_lane[0].r_active;
    assign out1    = g_lane[1].r_out;
    assign valid1  = g_lane[1].r_valid;
    assign active1 = g_lane[1].r_active;
    assign Error   = r_error;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: directed scenarios with literal timing/value checks, then random
// lane traffic compared every cycle against a bit-history model of the alignment rules.
module tb_serial_rx;

    localparam int MS = 8;
    localparam int CC = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in0 = 1'b0;
    logic       in1 = 1'b0;
    logic [7:0] out0, out1;
    logic       valid0, valid1, active0, active1, Error;

    serial_rx #(
        .MAIN_SIZE(MS),
        .COM(COM),
        .COM_COUNT(CC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in0(in0),
        .in1(in1),
        .out0(out0),
        .valid0(valid0),
        .active0(active0),
        .out1(out1),
        .valid1(valid1),
        .active1(active1),
        .Error(Error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus bit queues, one bit per lane per cycle, zeros when empty.
    bit q0[$];
    bit q1[$];

    initial begin
        forever begin
            @(negedge clk);
            in0 = (q0.size() > 0) ? q0.pop_front() : 1'b0;
            in1 = (q1.size() > 0) ? q1.pop_front() : 1'b0;
        end
    end

    task automatic push_bit(input int lane, input bit b);
        if (lane == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic push_byte(input int lane, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) push_bit(lane, v[i]);
    endtask

    // Reference model: the last MS received bits, mode, and age since alignment.
    typedef struct {
        int         mode;    // 0 search, 1 lock, 2 active
        int         age;
        int         ncom;
        logic [7:0] out;
        bit         valid;
        bit         active;
        bit         err;
    } lane_m_t;

    lane_m_t m0, m1;
    bit      h0[$];
    bit      h1[$];
    bit      exp_err;

    task automatic lane_step(inout lane_m_t m, input logic [7:0] sym);
        m.valid = 1'b0;
        m.err   = 1'b0;
        if (m.mode == 0) begin
            if (sym == COM) begin
                m.mode = 1;
                m.age  = 0;
                m.ncom = 1;
            end
        end else begin
            m.age++;
            if (m.age % MS == 0) begin
                if (m.mode == 1) begin
                    if (sym == COM) begin
                        m.ncom++;
                        if (m.ncom == CC) begin
                            m.mode   = 2;
                            m.active = 1'b1;
                        end
                    end else begin
                        m.mode = 0;
                        m.err  = 1'b1;
                    end
                end else if (sym != COM) begin
                    m.out   = sym;
                    m.valid = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        logic [7:0] s0, s1;
        if (!reset) begin
            h0.delete();
            h1.delete();
            m0 = '{default: 0};
            m1 = '{default: 0};
            exp_err = 1'b0;
        end else begin
            h0.push_back(in0);
            h1.push_back(in1);
            if (h0.size() > MS) void'(h0.pop_front());
            if (h1.size() > MS) void'(h1.pop_front());
            s0 = 8'h00;
            s1 = 8'h00;
            for (int i = 0; i < h0.size(); i++) s0 = (s0 << 1) | 8'(h0[i]);
            for (int i = 0; i < h1.size(); i++) s1 = (s1 << 1) | 8'(h1[i]);
            lane_step(m0, s0);
            lane_step(m1, s1);
            exp_err = m0.err | m1.err;
        end
    end

    always @(negedge clk) begin
        chk("out0", out0, m0.out);
        chk("valid0", valid0, m0.valid);
        chk("active0", active0, m0.active);
        chk("out1", out1, m1.out);
        chk("valid1", valid1, m1.valid);
        chk("active1", active1, m1.active);
        chk("Error", Error, exp_err);
    end

    // Event log used by the directed literal checks.
    logic [7:0] v0_val[$];
    logic [7:0] v1_val[$];
    int         v0_cyc[$];
    int         v1_cyc[$];
    int         rise0 = -1;
    int         rise1 = -1;
    int         err_n = 0;
    int         err_cyc = -1;
    bit         pa0 = 1'b0;
    bit         pa1 = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (valid0) begin
                v0_val.push_back(out0);
                v0_cyc.push_back(cyc);
            end
            if (valid1) begin
                v1_val.push_back(out1);
                v1_cyc.push_back(cyc);
            end
            if (Error) begin
                err_n++;
                err_cyc = cyc;
            end
            if (active0 && !pa0) rise0 = cyc;
            if (active1 && !pa1) rise1 = cyc;
        end
        pa0 = active0;
        pa1 = active1;
    end

    task automatic clr_mon();
        v0_val.delete();
        v1_val.delete();
        v0_cyc.delete();
        v1_cyc.delete();
        rise0   = -1;
        rise1   = -1;
        err_n   = 0;
        err_cyc = -1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out0"}, out0, 0);
        chk({tag, "_valid0"}, valid0, 0);
        chk({tag, "_active0"}, active0, 0);
        chk({tag, "_out1"}, out1, 0);
        chk({tag, "_valid1"}, valid1, 0);
        chk({tag, "_active1"}, active1, 0);
        chk({tag, "_Error"}, Error, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        q0.delete();
        q1.delete();
        #1 chk_zero("rst");
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        clr_mon();
    endtask

    task automatic drain(input int extra);
        for (int i = 0; i < 4000 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) chk("drain_timeout", 1, 0);
        repeat (extra) @(posedge clk);
        #2;
    endtask

    task automatic gen_lane(input int lane);
        logic [7:0] b;
        int         n;
        n = $urandom_range(0, 7);
        for (int i = 0; i < n; i++) push_bit(lane, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) push_byte(lane, COM);
            b = 8'($urandom_range(0, 255));
            if (b == COM) b = 8'h00;
            push_byte(lane, b);
        end
        for (int i = 0; i < CC; i++) push_byte(lane, COM);
        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) begin
            b = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom_range(0, 255));
            push_byte(lane, b);
        end
    endtask

    int p;

    initial begin
        // Reset and idle.
        repeat (3) @(posedge clk);
        #1 chk_zero("hold");
        #1 reset = 1'b1;
        clr_mon();
        p = cyc;
        wait_until(p + 40);
        chk("idle_v0_count", v0_val.size(), 0);
        chk("idle_v1_count", v1_val.size(), 0);
        chk("idle_rise0", rise0, -1);
        chk("idle_rise1", rise1, -1);
        chk("idle_err_n", err_n, 0);

        // Lock and data on lane 0.
        p = cyc;
        for (int i = 0; i < 4; i++) push_byte(0, COM);
        push_byte(0, 8'h5A);
        push_byte(0, 8'h3C);
        push_byte(0, COM);
        push_byte(0, COM);
        wait_until(p + 66);
        chk("lock_rise0", rise0, p + 32);
        chk("lock_v0_count", v0_val.size(), 2);
        if (v0_val.size() >= 2) begin
            chk("lock_byte0", v0_val[0], 8'h5A);
            chk("lock_byte0_cyc", v0_cyc[0], p + 40);
            chk("lock_byte1", v0_val[1], 8'h3C);
            chk("lock_gap", v0_cyc[1] - v0_cyc[0], 8);
        end
        chk("lock_hold", out0, 8'h3C);

        // Misaligned start on lane 1.
        do_reset();
        p = cyc;
        push_bit(1, 1'b1);
        push_bit(1, 1'b0);
        push_bit(1, 1'b1);
        for (int i = 0; i < 4; i++) push_byte(1, COM);
        push_byte(1, 8'hA5);
        push_byte(1, COM);
        wait_until(p + 52);
        chk("mis_rise1", rise1, p + 35);
        chk("mis_active1", active1, 1);
        chk("mis_v1_count", v1_val.size(), 1);
        if (v1_val.size() >= 1) chk("mis_byte", v1_val[0], 8'hA5);
        chk("mis_rise0", rise0, -1);

        // Lock break on lane 0.
        do_reset();
        p = cyc;
        push_byte(0, COM);
        push_byte(0, COM);
        push_byte(0, 8'h11);
        for (int i = 0; i < 4; i++) push_byte(0, COM);
        push_byte(0, 8'h22);
        push_byte(0, COM);
        wait_until(p + 70);
        chk("brk_err_n", err_n, 1);
        chk("brk_err_cyc", err_cyc, p + 24);
        chk("brk_rise0", rise0, p + 56);
        chk("brk_v0_count", v0_val.size(), 1);
        if (v0_val.size() >= 1) begin
            chk("brk_byte", v0_val[0], 8'h22);
            chk("brk_byte_cyc", v0_cyc[0], p + 64);
        end

        // Idle insertion in ACTIVE.
        do_reset();
        p = cyc;
        for (int i = 0; i < 4; i++) push_byte(0, COM);
        push_byte(0, 8'h01);
        push_byte(0, COM);
        push_byte(0, COM);
        push_byte(0, 8'h02);
        push_byte(0, COM);
        wait_until(p + 70);
        chk("idl_v0_count", v0_val.size(), 2);
        if (v0_val.size() >= 2) begin
            chk("idl_byte0", v0_val[0], 8'h01);
            chk("idl_byte1", v0_val[1], 8'h02);
            chk("idl_gap", v0_cyc[1] - v0_cyc[0], 24);
        end

        // Reset three bits into a byte with both lanes ACTIVE.
        do_reset();
        p = cyc;
        for (int i = 0; i < 4; i++) begin
            push_byte(0, COM);
            push_byte(1, COM);
        end
        push_byte(0, 8'h77);
        push_byte(1, 8'h77);
        wait_until(p + 42);
        chk("mid_active0", active0, 1);
        chk("mid_active1", active1, 1);
        chk("mid_out0", out0, 8'h77);
        wait_until(p + 43);
        reset = 1'b0;
        #1 chk_zero("mid");
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        clr_mon();
        p = cyc;
        for (int i = 0; i < 4; i++) begin
            push_byte(0, COM);
            push_byte(1, COM);
        end
        push_byte(0, 8'h55);
        push_byte(1, 8'h55);
        push_byte(0, COM);
        push_byte(1, COM);
        wait_until(p + 45);
        chk("re_rise0", rise0, p + 32);
        chk("re_rise1", rise1, p + 32);
        chk("re_v0_count", v0_val.size(), 1);
        if (v0_val.size() >= 1) chk("re_byte0", v0_val[0], 8'h55);

        // Random traffic against the model.
        for (int r = 0; r < 24; r++) begin
            do_reset();
            gen_lane(0);
            gen_lane(1);
            if (r % 3 == 2) begin
                repeat ($urandom_range(20, 80)) @(posedge clk);
                #2;
            end else begin
                drain(MS + 4);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
